ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte to the keyboard (LED set 0xED, reset 0xFF, typematic 0xF3, etc.) using the standard request-to-send sequence. It then checks the device acknowledge.
- Drives the open-drain PS/2 clock and data lines alongside the existing receive path.
- Asserts `rx_inhibit` so the receive decoder ignores line activity while a transmission is in progress.

Parameters:
- CLK_FREQ, 28000000, system clock frequency in Hz. Used to derive all timing counts.
- INHIBIT_US, 100, time the clock line is held low before the start bit.
- SETUP_US, 5, time data is held low together with clock before the clock is released.
- TIMEOUT_US, 15000, maximum time from clock release to acknowledge before the transfer is aborted.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- ps2_clk_in  in  1  raw PS/2 clock line; asynchronous.
- ps2_dat_in  in  1  raw PS/2 data line; asynchronous.
- ps2_clk_out  out  1  open-drain control: 0 pulls the line low, 1 releases it.
- ps2_dat_out  out  1  open-drain control: 0 pulls the line low, 1 releases it.
- tx_data  in  8  byte to send.
- tx_valid  in  1  request to send `tx_data`.
- tx_ready  out  1  high only in IDLE; a byte is accepted on the cycle where `tx_valid && tx_ready`.
- tx_done  out  1  one-cycle pulse: byte acknowledged by the device.
- tx_error  out  1  one-cycle pulse: missing acknowledge or timeout.
- rx_inhibit  out  1  high in every state except IDLE.

Behaviour:
- Reset is synchronous and active-high. When `rst`=1 on a clock edge:
  - state returns to IDLE;
  - `ps2_clk_out`=1, `ps2_dat_out`=1;
  - `tx_ready`=1, `tx_done`=0, `tx_error`=0, `rx_inhibit`=0;
  - all counters are cleared.
- Reset mid-transfer releases both lines on the next edge. No `tx_done` or `tx_error` pulse is emitted.
- Input conditioning:
  - each line passes through a 2-FF synchroniser, then a 3-sample majority filter;
  - `fall` = filtered clock was 1 on the previous cycle and is 0 now.
- Cycle counts are computed as CLK_FREQ/1000000 × the `_US` value, using integer division.
- Counter width is the clog2 of the largest count.
- The shift register is 10 bits wide and is loaded on accept as {stop=1, parity, tx_data}.
  - Parity is odd: the complement of the XOR reduction of `tx_data`.
- State machine:
  - IDLE: both lines released. On accept, latch the frame and go to INHIBIT.
  - INHIBIT: `ps2_clk_out`=0, `ps2_dat_out`=1 for INHIBIT cycles, then go to REQ.
  - REQ: `ps2_clk_out`=0, `ps2_dat_out`=0 (start bit) for SETUP cycles. Then set `ps2_clk_out`=1, clear `bitcnt` and the timeout counter, and go to SEND.
  - SEND:
    - on each `fall`, drive `ps2_dat_out` = shift[0], shift right, and increment `bitcnt`;
    - falls 1–8 send d0..d7 (LSB first), fall 9 sends parity, fall 10 sends stop (line released);
    - after fall 10, go to ACK.
  - ACK: `ps2_dat_out`=1. On the next `fall`, sample the filtered data line:
    - 0: go to WAIT_REL;
    - 1: pulse `tx_error` and go to IDLE.
  - WAIT_REL: wait until filtered clock and data are both 1, then pulse `tx_done` and go to IDLE.
- Timeout:
  - the counter runs through SEND, ACK and WAIT_REL and never resets on edges;
  - when it reaches TIMEOUT cycles: release both lines, pulse `tx_error`, go to IDLE.
  - Timeout has priority over a `fall` that occurs in the same cycle.
- Back-pressure:
  - `tx_valid` while busy is ignored; the byte is not queued;
  - `tx_ready` first re-asserts on the cycle after a `tx_done` or `tx_error` pulse;
  - `tx_valid` held high through `tx_done` is accepted again in IDLE.
- `tx_done` and `tx_error` are mutually exclusive and are never both high in the same cycle.
- Latency from accept to start bit on the line = 1 + INHIBIT cycles.

Test Plan:
- Bench setup: CLK_FREQ=1000000, so INHIBIT=100, SETUP=5, TIMEOUT=15000. The device model generates a 12.5 kHz clock and pulls data low on fall 11.
1. `tx_data`=0xED accepted:
   - `ps2_clk_out` low for exactly 100 cycles;
   - data low for 5 cycles before clock release;
   - bits sampled on device rising edges are 1,0,1,1,0,1,1,1, parity 1, stop 1;
   - ack, then one `tx_done` pulse; `tx_ready`=1 on the cycle after.
2. `tx_data`=0x01 → parity bit 0; `tx_data`=0xFF → parity bit 1; `tx_data`=0x00 → parity bit 1. Each finishes with `tx_done`.
3. Device model never pulls data low on fall 11 → `tx_error` pulse right after fall 11, no `tx_done`, both lines released.
4. Device never clocks after release → `tx_error` exactly 15000 cycles after `ps2_clk_out` rises, both lines released, back in IDLE.
5. Second `tx_valid` with 0xF3 at fall 4 of a 0xED transfer → ignored; the line carries only 0xED; 0xF3 is accepted after `tx_done` only if `tx_valid` is still high.
6. `rst`=1 during fall 6 of a transfer → next edge gives `ps2_clk_out`=1, `ps2_dat_out`=1, `rx_inhibit`=0, `tx_ready`=1, and no `tx_done` or `tx_error` pulse.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame clocked out by the
// device, acknowledge check and a watchdog covering the whole device-clocked phase.
module ps2_host_tx #(
  parameter int CLK_FREQ   = 28000000,
  parameter int INHIBIT_US = 100,
  parameter int SETUP_US   = 5,
  parameter int TIMEOUT_US = 15000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_out,
  output logic       ps2_dat_out,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_inhibit
);

  localparam int CYC_US      = CLK_FREQ / 1000000;
  localparam int INHIBIT_CYC = CYC_US * INHIBIT_US;
  localparam int SETUP_CYC   = CYC_US * SETUP_US;
  localparam int TIMEOUT_CYC = CYC_US * TIMEOUT_US;
  localparam int MAX_A       = (INHIBIT_CYC > SETUP_CYC) ? INHIBIT_CYC : SETUP_CYC;
  localparam int MAX_CYC     = (MAX_A > TIMEOUT_CYC) ? MAX_A : TIMEOUT_CYC;
  localparam int CW          = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] ONE_C      = CW'(1);
  localparam logic [CW-1:0] INH_LAST_C = CW'(INHIBIT_CYC - 1);
  localparam logic [CW-1:0] SET_LAST_C = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] TO_LAST_C  = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INHIBIT  = 3'd1,
    ST_REQ      = 3'd2,
    ST_SEND     = 3'd3,
    ST_ACK      = 3'd4,
    ST_WAIT_REL = 3'd5
  } state_t;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  function automatic logic odd_parity(input logic [7:0] d);
    return ~(^d);
  endfunction

  state_t        state_r, state_nxt_s;
  logic [1:0]    clk_sync_r, dat_sync_r;
  logic [2:0]    clk_hist_r, dat_hist_r;
  logic          clk_f_r, dat_f_r, clk_prev_r;
  logic [CW-1:0] cnt_r, tout_r;
  logic [3:0]    bitcnt_r;
  logic [9:0]    shift_r;
  logic          clk_out_r, dat_out_r, ready_r, done_r, err_r, inhibit_r;
  logic          clk_out_nxt_s, dat_out_nxt_s, ready_nxt_s, inhibit_nxt_s;
  logic          done_nxt_s, err_nxt_s;
  logic          fall_s, accept_s, timeout_s, busy_s;

  assign fall_s    = clk_prev_r & ~clk_f_r;
  assign accept_s  = (state_r == ST_IDLE) & tx_valid & ready_r;
  assign busy_s    = (state_r == ST_SEND) | (state_r == ST_ACK) | (state_r == ST_WAIT_REL);
  assign timeout_s = busy_s & (tout_r == TO_LAST_C);

  // Line conditioning: 2-FF synchroniser, 3-sample majority filter, falling-edge history.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_r <= 2'b11;
      dat_sync_r <= 2'b11;
      clk_hist_r <= 3'b111;
      dat_hist_r <= 3'b111;
      clk_f_r    <= 1'b1;
      dat_f_r    <= 1'b1;
      clk_prev_r <= 1'b1;
    end else begin
      clk_sync_r <= {clk_sync_r[0], ps2_clk_in};
      dat_sync_r <= {dat_sync_r[0], ps2_dat_in};
      clk_hist_r <= {clk_hist_r[1:0], clk_sync_r[1]};
      dat_hist_r <= {dat_hist_r[1:0], dat_sync_r[1]};
      clk_f_r    <= maj3(clk_hist_r);
      dat_f_r    <= maj3(dat_hist_r);
      clk_prev_r <= clk_f_r;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; the watchdog outranks a fall arriving in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    done_nxt_s  = 1'b0;
    err_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_INHIBIT;
        else          state_nxt_s = ST_IDLE;
      end
      ST_INHIBIT: begin
        if (cnt_r == INH_LAST_C) state_nxt_s = ST_REQ;
        else                     state_nxt_s = ST_INHIBIT;
      end
      ST_REQ: begin
        if (cnt_r == SET_LAST_C) state_nxt_s = ST_SEND;
        else                     state_nxt_s = ST_REQ;
      end
      ST_SEND: begin
        if (timeout_s) begin
          state_nxt_s = ST_IDLE;
          err_nxt_s   = 1'b1;
        end else if (fall_s && (bitcnt_r == 4'd9)) begin
          state_nxt_s = ST_ACK;
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      ST_ACK: begin
        if (timeout_s) begin
          state_nxt_s = ST_IDLE;
          err_nxt_s   = 1'b1;
        end else if (fall_s) begin
          if (!dat_f_r) begin
            state_nxt_s = ST_WAIT_REL;
          end else begin
            state_nxt_s = ST_IDLE;
            err_nxt_s   = 1'b1;
          end
        end else begin
          state_nxt_s = ST_ACK;
        end
      end
      ST_WAIT_REL: begin
        if (timeout_s) begin
          state_nxt_s = ST_IDLE;
          err_nxt_s   = 1'b1;
        end else if (clk_f_r && dat_f_r) begin
          state_nxt_s = ST_IDLE;
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT_REL;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode; the data line holds its last driven bit between device clock falls.
  always_comb begin
    clk_out_nxt_s = 1'b1;
    dat_out_nxt_s = 1'b1;
    case (state_nxt_s)
      ST_INHIBIT: begin
        clk_out_nxt_s = 1'b0;
        dat_out_nxt_s = 1'b1;
      end
      ST_REQ: begin
        clk_out_nxt_s = 1'b0;
        dat_out_nxt_s = 1'b0;
      end
      ST_SEND: begin
        clk_out_nxt_s = 1'b1;
        if (state_r != ST_SEND) dat_out_nxt_s = 1'b0;
        else if (fall_s)        dat_out_nxt_s = shift_r[0];
        else                    dat_out_nxt_s = dat_out_r;
      end
      default: begin
        clk_out_nxt_s = 1'b1;
        dat_out_nxt_s = 1'b1;
      end
    endcase
    ready_nxt_s   = (state_nxt_s == ST_IDLE) & ~done_nxt_s & ~err_nxt_s;
    inhibit_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_out_r <= 1'b1;
      dat_out_r <= 1'b1;
      ready_r   <= 1'b1;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      inhibit_r <= 1'b0;
    end else begin
      clk_out_r <= clk_out_nxt_s;
      dat_out_r <= dat_out_nxt_s;
      ready_r   <= ready_nxt_s;
      done_r    <= done_nxt_s;
      err_r     <= err_nxt_s;
      inhibit_r <= inhibit_nxt_s;
    end
  end

  // Phase counter, watchdog counter, bit counter and frame shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= '0;
      tout_r   <= '0;
      bitcnt_r <= 4'd0;
      shift_r  <= 10'h3FF;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r    <= '0;
          tout_r   <= '0;
          bitcnt_r <= 4'd0;
          if (accept_s) shift_r <= {1'b1, odd_parity(tx_data), tx_data};
        end
        ST_INHIBIT: begin
          if (cnt_r == INH_LAST_C) cnt_r <= '0;
          else                     cnt_r <= cnt_r + ONE_C;
        end
        ST_REQ: begin
          if (cnt_r == SET_LAST_C) begin
            cnt_r    <= '0;
            tout_r   <= '0;
            bitcnt_r <= 4'd0;
          end else begin
            cnt_r <= cnt_r + ONE_C;
          end
        end
        ST_SEND: begin
          tout_r <= tout_r + ONE_C;
          if (fall_s) begin
            shift_r  <= {1'b1, shift_r[9:1]};
            bitcnt_r <= bitcnt_r + 4'd1;
          end
        end
        ST_ACK, ST_WAIT_REL: tout_r <= tout_r + ONE_C;
        default: begin
          cnt_r    <= '0;
          tout_r   <= '0;
          bitcnt_r <= 4'd0;
        end
      endcase
    end
  end

  assign ps2_clk_out = clk_out_r;
  assign ps2_dat_out = dat_out_r;
  assign tx_ready    = ready_r;
  assign tx_done     = done_r;
  assign tx_error    = err_r;
  assign rx_inhibit  = inhibit_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a behavioural PS/2 device on wired-AND lines,
// a reference frame model, and independent monitors for requests, frames and results.
module tb_ps2_host_tx;

  localparam int INH  = 100;
  localparam int SET  = 5;
  localparam int TOUT = 15000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2_clk_out, ps2_dat_out, tx_ready, tx_done, tx_error, rx_inhibit;
  logic       line_clk, line_dat;

  assign line_clk = ps2_clk_out & dev_clk;
  assign line_dat = ps2_dat_out & dev_dat;

  ps2_host_tx #(.CLK_FREQ(1000000), .INHIBIT_US(100), .SETUP_US(5), .TIMEOUT_US(15000)) dut (
    .clk(clk), .rst(rst),
    .ps2_clk_in(line_clk), .ps2_dat_in(line_dat),
    .ps2_clk_out(ps2_clk_out), .ps2_dat_out(ps2_dat_out),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_done(tx_done), .tx_error(tx_error), .rx_inhibit(rx_inhibit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  logic [9:0] exp_frame_q[$];
  logic [9:0] cap_frame_q[$];
  int exp_res_q[$];           // 0 = done, 1 = missing ack, 2 = timeout
  int exp_total = 0;
  int results_seen = 0;
  int last_res_cyc = 0;
  int last_acc_cyc = 0;
  int rel_cyc = 0;
  int fall11_cyc = 0;
  int accepts = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference frame: data LSB first, odd parity, stop bit 1; index i = bit on rising edge i+1.
  function automatic logic [9:0] ref_frame(input logic [7:0] d);
    int   ones;
    logic par;
    ones = $countones(d);
    par  = ((ones % 2) == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, d};
  endfunction

  task automatic expect_txn(input logic [7:0] d, input bit framed, input int res);
    if (framed) exp_frame_q.push_back(ref_frame(d));
    exp_res_q.push_back(res);
    exp_total++;
  endtask

  task automatic send(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      if (tx_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    tx_valid = 1'b0;
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL accept_wait: tx_ready never seen, got 0, expected 1");
    end
  endtask

  task automatic wait_results(input int target, input int bound);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < bound; n++) begin
      if (results_seen >= target) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL result_wait: results seen %0d, expected %0d", results_seen, target);
    end
  endtask

  // Device: waits for request-to-send, issues 11 clocks, samples on rising edges.
  // hook_kind 1 = raise tx_valid with 0xF3 and leave it, 2 = reset pulse, 3 = one-cycle tx_valid.
  task automatic device_txn(input int half, input bit do_ack, input int hook_fall,
                            input int hook_kind, input bit record);
    logic [9:0] cap;
    bit seen;
    cap  = 10'h000;
    seen = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      if (line_clk && !line_dat) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL request_wait: clock release with start bit not seen, got 0, expected 1");
      return;
    end
    repeat (20) begin @(posedge clk); #1; end
    for (int f = 1; f <= 11; f++) begin
      dev_clk = 1'b0;
      if (f == 11) fall11_cyc = cyc;
      for (int k = 0; k < half; k++) begin
        @(posedge clk); #1;
        if (f == hook_fall && k == 6) begin
          case (hook_kind)
            1, 3:    begin tx_data = 8'hF3; tx_valid = 1'b1; end
            2:       rst = 1'b1;
            default: ;
          endcase
        end
        if (f == hook_fall && k == 7) begin
          case (hook_kind)
            2: begin
              check("rst_clk_out", ps2_clk_out, 1);
              check("rst_dat_out", ps2_dat_out, 1);
              check("rst_rx_inhibit", rx_inhibit, 0);
              check("rst_tx_ready", tx_ready, 1);
              check("rst_no_done", tx_done, 0);
              check("rst_no_error", tx_error, 0);
              rst = 1'b0;
            end
            3:       tx_valid = 1'b0;
            default: ;
          endcase
        end
      end
      if (f <= 10) cap[f-1] = line_dat;
      dev_clk = 1'b1;
      if (f == 10 && do_ack) dev_dat = 1'b0;
      if (f == 11) dev_dat = 1'b1;
      repeat (half) begin @(posedge clk); #1; end
    end
    if (record) cap_frame_q.push_back(cap);
  endtask

  // Request monitor: inhibit length, setup length and accept-to-start-bit latency.
  initial begin
    int phase, n_inh, n_set, lat, acc;
    phase = 0; n_inh = 0; n_set = 0; lat = -1; acc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        phase = 0;
      end else if (phase == 0) begin
        if (tx_valid && tx_ready) begin
          phase = 1; acc = cyc; last_acc_cyc = cyc;
          n_inh = 0; n_set = 0; lat = -1; accepts++;
        end
      end else if (!ps2_clk_out && ps2_dat_out) begin
        n_inh++;
      end else if (!ps2_clk_out && !ps2_dat_out) begin
        if (n_set == 0) lat = cyc - acc;
        n_set++;
      end else begin
        check("inhibit_len", n_inh, INH);
        check("setup_len", n_set, SET);
        check("start_latency", lat, 1 + INH);
        check("start_bit_at_release", ps2_dat_out, 0);
        rel_cyc = cyc;
        phase = 0;
      end
    end
  end

  // Frame monitor: bits the device sampled against the reference model.
  initial begin
    logic [9:0] got, want;
    forever begin
      @(negedge clk);
      while (cap_frame_q.size() > 0) begin
        got = cap_frame_q.pop_front();
        if (exp_frame_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL frame_unexpected: got %03h, expected no frame", got);
        end else begin
          want = exp_frame_q.pop_front();
          check("frame_bits", int'(got), int'(want));
        end
      end
    end
  end

  // Result monitor: done/error pulses, timing of error causes, state on the following cycle.
  initial begin
    int k, d;
    bit pend;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        check("ready_after_pulse", tx_ready, 1);
        check("clk_released_after", ps2_clk_out, 1);
        check("dat_released_after", ps2_dat_out, 1);
        check("inhibit_low_after", rx_inhibit, 0);
        pend = 1'b0;
      end
      if (tx_done || tx_error) begin
        check("done_error_exclusive", int'(tx_done & tx_error), 0);
        check("ready_low_during_pulse", tx_ready, 0);
        if (exp_res_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL result_unexpected: done=%0b error=%0b, expected no pulse", tx_done, tx_error);
        end else begin
          k = exp_res_q.pop_front();
          check("result_is_done", int'(tx_done), (k == 0) ? 1 : 0);
          if (k == 2) check("timeout_cycles", cyc - rel_cyc, TOUT);
          if (k == 1) begin
            d = cyc - fall11_cyc;
            check("noack_error_promptly", (d >= 1 && d <= 12) ? 1 : 0, 1);
          end
        end
        results_seen++;
        last_res_cyc = cyc;
        pend = 1'b1;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    bit ack;
    int half, acc_before;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_clk_out", ps2_clk_out, 1);
    check("reset_dat_out", ps2_dat_out, 1);
    check("reset_tx_ready", tx_ready, 1);
    check("reset_tx_done", tx_done, 0);
    check("reset_tx_error", tx_error, 0);
    check("reset_rx_inhibit", rx_inhibit, 0);
    rst = 1'b0;

    // LED command, then parity corner bytes
    expect_txn(8'hED, 1'b1, 0);
    send(8'hED); device_txn(40, 1'b1, 0, 0, 1'b1); wait_results(exp_total, 2000);
    foreach (rd[i]) rd[i] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd = (i == 0) ? 8'h01 : (i == 1) ? 8'hFF : 8'h00;
      expect_txn(rd, 1'b1, 0);
      send(rd); device_txn(40, 1'b1, 0, 0, 1'b1); wait_results(exp_total, 2000);
    end

    // Device withholds acknowledge
    expect_txn(8'hFF, 1'b1, 1);
    send(8'hFF); device_txn(40, 1'b0, 0, 0, 1'b1); wait_results(exp_total, 2000);

    // Device never clocks
    expect_txn(8'hF4, 1'b0, 2);
    send(8'hF4); wait_results(exp_total, 16000);

    // Request while busy, held through tx_done: accepted right after
    expect_txn(8'hED, 1'b1, 0);
    expect_txn(8'hF3, 1'b1, 0);
    send(8'hED); device_txn(40, 1'b1, 4, 1, 1'b1);
    check("f3_accept_after_done", last_acc_cyc - last_res_cyc, 1);
    @(posedge clk); #1; tx_valid = 1'b0;
    device_txn(40, 1'b1, 0, 0, 1'b1); wait_results(exp_total, 2000);

    // Request while busy, dropped before tx_done: never accepted
    acc_before = accepts;
    expect_txn(8'hED, 1'b1, 0);
    send(8'hED); device_txn(40, 1'b1, 4, 3, 1'b1); wait_results(exp_total, 2000);
    repeat (200) begin @(posedge clk); #1; end
    check("dropped_request_ignored", accepts - acc_before, 1);
    check("idle_after_dropped", rx_inhibit, 0);

    // Reset during fall 6
    send(8'hED); device_txn(40, 1'b0, 6, 2, 1'b0);
    repeat (100) begin @(posedge clk); #1; end
    check("idle_after_reset", rx_inhibit, 0);

    // Random bytes, device rates and acknowledge behaviour
    for (int i = 0; i < 6; i++) begin
      rd   = 8'($urandom_range(0, 255));
      ack  = ($urandom_range(0, 3) != 0);
      half = $urandom_range(30, 50);
      expect_txn(rd, 1'b1, ack ? 0 : 1);
      send(rd); device_txn(half, ack, 0, 0, 1'b1); wait_results(exp_total, 2000);
    end

    repeat (20) begin @(posedge clk); #1; end
    check("frames_outstanding", exp_frame_q.size(), 0);
    check("results_outstanding", exp_res_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
